pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed EX/MEM pipeline register.
- Carries one pipeline slot (control bits plus data payload) between two stages using a valid/ready handshake.
- Adds stall back-pressure, synchronous flush, and an optional skid entry so the stage sustains full throughput with a registered in_ready.
- Instantiated between any adjacent pair of core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot_reg.sv | 53 +++++
 rtl/pipe_stage_buf.sv | 138 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths and control-field layout for the pipeline stage buffers.
package pipe_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // ALUResult + WriteData + Rd + PCPlus4
  localparam int unsigned EM_DATA_W  = 2*XLEN + REG_ADDR_W + XLEN;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } pipe_em_ctrl_t;

  localparam int unsigned EM_CTRL_W  = $bits(pipe_em_ctrl_t);

endpackage

// File: rtl/pipe_slot_reg.sv
// One pipeline slot entry: valid + ctrl + data with load and clear enables.
// load wins over clr; clr drops only the valid bit, payload is kept.
module pipe_slot_reg #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-state for the entry.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with stall, flush and optional skid entry.
// Optional perf counters (stall_cnt, kill_cnt) under PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EM_CTRL_W,
  parameter int unsigned DATA_W = EM_DATA_W,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
`endif
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl;
  logic [DATA_W-1:0] m_data,  s_data;
  logic              m_load, m_clr, m_from_s, s_load, s_clr;
  logic              push, pop;
  logic [CTRL_W-1:0] m_ctrl_in;
  logic [DATA_W-1:0] m_data_in;

  // With a skid entry in_ready comes straight off a flop; without, it looks through.
  assign in_ready = SKID ? !s_valid : (!m_valid || out_ready);
  assign push     = in_valid && in_ready;
  assign pop      = m_valid && out_ready;

  // Entry update priority: flush, then refill M (from S first), then spill into S.
  always_comb begin
    m_load   = 1'b0;
    m_clr    = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clr    = 1'b0;
    if (flush_i) begin
      m_clr = 1'b1;
      s_clr = 1'b1;
    end else if (!m_valid || pop) begin
      if (s_valid) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        s_clr    = 1'b1;
        s_load   = push;
      end else if (push) begin
        m_load = 1'b1;
      end else begin
        m_clr = 1'b1;
      end
    end else if (push && SKID) begin
      s_load = 1'b1;
    end
  end

  assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl;
  assign m_data_in = m_from_s ? s_data : in_data;

  pipe_slot_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (m_load),
    .clr_i   (m_clr),
    .ctrl_i  (m_ctrl_in),
    .data_i  (m_data_in),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  if (SKID) begin : g_skid
    pipe_slot_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (s_load),
      .clr_i   (s_clr),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .data_o  (s_data)
    );
  end else begin : g_no_skid
    assign s_valid = 1'b0;
    assign s_ctrl  = '0;
    assign s_data  = '0;
  end

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q,  kill_cnt_d;

  // Saturating stall and kill counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (m_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_i && (m_valid || s_valid) && (kill_cnt_q != {CNT_W{1'b1}}))
      kill_cnt_d = kill_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`else
  // Counter width is meaningless without the counters.
  logic unused_cnt_w;
  assign unused_cnt_w = ^32'(CNT_W);
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (SKID=1, default widths).
module tb_pipe_stage_buf;

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 101;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt, kill_cnt;
  logic [1:0]    stall_cnt2, kill_cnt2;
  logic          in_ready2, out_valid2;
  logic [CW-1:0] out_ctrl2;
  logic [DW-1:0] out_data2;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .stall_cnt(stall_cnt2), .kill_cnt(kill_cnt2)
  );
`endif

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0);
    #3;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_ctrl",  128'(out_ctrl),  128'd0);
    check("rst_out_data",  128'(out_data),  128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    step(); step();
    rst = 1'b0;

    // Single push
    drive(1'b1, 4'b1011, 101'h5);
    check("single_in_ready_pre", 128'(in_ready), 128'd1);
    step();
    check("single_out_valid", 128'(out_valid), 128'd1);
    check("single_out_ctrl",  128'(out_ctrl),  128'hb);
    check("single_out_data",  128'(out_data),  128'h5);
    check("single_in_ready",  128'(in_ready),  128'd1);
    drive(1'b0, '0, '0);
    step();
    check("single_drain_valid", 128'(out_valid), 128'd0);
    check("single_drain_ctrl",  128'(out_ctrl),  128'd0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 101'(i));
      step();
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_data",  128'(out_data),  128'(i));
      check("stream_ctrl",  128'(out_ctrl),  128'(i));
      check("stream_ready", 128'(in_ready),  128'd1);
    end
    drive(1'b0, '0, '0);
    step();
    check("stream_end_valid", 128'(out_valid), 128'd0);

    // Stall and skid
    out_ready = 1'b0;
    drive(1'b1, 4'h1, 101'h11);
    step();
    check("stall_a_data",  128'(out_data), 128'h11);
    check("stall_a_ready", 128'(in_ready), 128'd1);
    drive(1'b1, 4'h2, 101'h22);
    step();
    check("stall_b_data",  128'(out_data), 128'h11);
    check("stall_b_ready", 128'(in_ready), 128'd0);
    drive(1'b0, '0, '0);
    step();
    check("stall_hold_data", 128'(out_data), 128'h11);
    check("stall_hold_ctrl", 128'(out_ctrl), 128'h1);
    out_ready = 1'b1;
    step();
    check("skid_pop_data",  128'(out_data),  128'h22);
    check("skid_pop_ctrl",  128'(out_ctrl),  128'h2);
    check("skid_pop_ready", 128'(in_ready),  128'd1);
    step();
    check("skid_empty", 128'(out_valid), 128'd0);

    // Flush with both entries full
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 101'h44);
    step();
    drive(1'b1, 4'h4, 101'h55);
    step();
    check("full_ready", 128'(in_ready), 128'd0);
    flush_i = 1'b1;
    drive(1'b1, 4'h5, 101'h33);
    step();
    check("flush_valid", 128'(out_valid), 128'd0);
    check("flush_ctrl",  128'(out_ctrl),  128'd0);
    check("flush_ready", 128'(in_ready),  128'd1);

    // Flush with a real same-cycle push (M held, S empty)
    flush_i = 1'b0;
    drive(1'b1, 4'h6, 101'h66);
    step();
    flush_i = 1'b1;
    drive(1'b1, 4'h5, 101'h33);
    check("flush2_push_ready", 128'(in_ready), 128'd1);
    step();
    check("flush2_valid", 128'(out_valid), 128'd0);
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_emit", 128'(out_valid), 128'd0);
    end

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 4'h7, 101'h77);
    step();
    drive(1'b1, 4'h8, 101'h88);
    step();
    drive(1'b0, '0, '0);
    check("pre_arst_valid", 128'(out_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'd0);
    check("arst_ctrl",  128'(out_ctrl),  128'd0);
    check("arst_data",  128'(out_data),  128'd0);
    check("arst_ready", 128'(in_ready),  128'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_arst_valid", 128'(out_valid), 128'd0);

`ifdef PIPE_STAGE_PERF_CNT_EN
    check("cnt_rst_stall", 128'(stall_cnt), 128'd0);
    check("cnt_rst_kill",  128'(kill_cnt),  128'd0);
    out_ready = 1'b0;
    drive(1'b1, 4'h9, 101'h99);
    step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step();
    check("cnt_stall5",  128'(stall_cnt),  128'd5);
    check("cnt_stall_sat", 128'(stall_cnt2), 128'd3);
    flush_i = 1'b1;
    out_ready = 1'b1;
    step();
    flush_i = 1'b0;
    check("cnt_kill",   128'(kill_cnt),   128'd1);
    check("cnt_kill2",  128'(kill_cnt2),  128'd1);
    check("cnt_stall_after", 128'(stall_cnt), 128'd5);
    check("cnt2_valid", 128'(out_valid2), 128'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
